// File: rtl/rx_frame_fifo_if.sv
// AXI-Stream link used on both sides of the Rx frame buffer.
// master drives tdata/tkeep/tvalid/tlast/tuser; slave drives tready.
interface rx_frame_fifo_if #(
  parameter int DATA_WIDTH = 32
);
  localparam int DATA_NBYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0]  tdata;
  logic [DATA_NBYTES-1:0] tkeep;
  logic                   tvalid;
  logic                   tready;
  logic                   tlast;
  logic                   tuser;

  modport master (
    output tdata, tkeep, tvalid, tlast, tuser,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tvalid, tlast, tuser,
    output tready
  );
endinterface

// File: rtl/rx_frame_fifo.sv
// Store-and-forward Rx frame buffer: commits clean frames, rolls back bad/overflowed ones.
// Ports: i_clk, i_reset_n, s00_axis (slave), m00_axis (master), o_drop_err/o_drop_ovf, o_level.
module rx_frame_fifo #(
  parameter  int DATA_WIDTH  = 32,
  parameter  int DEPTH       = 512,
  localparam int DATA_NBYTES = DATA_WIDTH / 8,
  localparam int ADDR_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  rx_frame_fifo_if.slave        s00_axis,
  rx_frame_fifo_if.master       m00_axis,
  output logic                  o_drop_err,
  output logic                  o_drop_ovf,
  output logic [ADDR_WIDTH:0]   o_level
);

  localparam int WORD_W = DATA_WIDTH + DATA_NBYTES + 1;
  localparam logic [ADDR_WIDTH:0] LVL_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {SYNC, ACCEPT, DISCARD} wr_state_t;

  wr_state_t state, state_n;

  logic [ADDR_WIDTH:0] wr_ptr, wr_ptr_n;
  logic [ADDR_WIDTH:0] wr_commit, wr_commit_n;
  logic [ADDR_WIDTH:0] rd_ptr, rd_ptr_n;

  logic we, drop_err_n, drop_ovf_n;
  logic full, avail, rd_en, rd_pend, push, pop;
  logic [1:0] sk_cnt;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] ram_q, sk0, sk1;

  assign full  = (wr_ptr - rd_ptr) == LVL_FULL;
  assign avail = rd_ptr != wr_commit;
  assign pop   = m00_axis.tvalid && m00_axis.tready;
  assign push  = rd_pend;

  // Issue a RAM read only if the word can land in the skid stage
  // next cycle, counting the read already in flight.
  assign rd_en = avail &&
    ({1'b0, sk_cnt} + {2'b0, rd_pend} <= 3'd1 + {2'b0, pop});

  assign rd_ptr_n = rd_ptr + {{ADDR_WIDTH{1'b0}}, rd_en};

  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    wr_commit_n = wr_commit;
    we          = 1'b0;
    drop_err_n  = 1'b0;
    drop_ovf_n  = 1'b0;
    if (s00_axis.tvalid) begin
      unique case (state)
        SYNC: begin
          if (s00_axis.tlast) state_n = ACCEPT;
        end
        ACCEPT: begin
          if (!full) begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + 1'b1;
            if (s00_axis.tlast) begin
              if (s00_axis.tuser) begin
                wr_ptr_n   = wr_commit;
                drop_err_n = 1'b1;
              end else begin
                wr_commit_n = wr_ptr + 1'b1;
              end
            end
          end else if (s00_axis.tlast) begin
            wr_ptr_n   = wr_commit;
            drop_ovf_n = 1'b1;
          end else begin
            state_n = DISCARD;
          end
        end
        DISCARD: begin
          if (s00_axis.tlast) begin
            wr_ptr_n   = wr_commit;
            drop_ovf_n = 1'b1;
            state_n    = ACCEPT;
          end
        end
        default: state_n = SYNC;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= SYNC;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      rd_ptr     <= '0;
      rd_pend    <= 1'b0;
      o_drop_err <= 1'b0;
      o_drop_ovf <= 1'b0;
      o_level    <= '0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      wr_commit  <= wr_commit_n;
      rd_ptr     <= rd_ptr_n;
      rd_pend    <= rd_en;
      o_drop_err <= drop_err_n;
      o_drop_ovf <= drop_ovf_n;
      o_level    <= wr_ptr_n - rd_ptr_n;
    end
  end

  always_ff @(posedge i_clk) begin
    if (we)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <=
        {s00_axis.tlast, s00_axis.tkeep, s00_axis.tdata};
    if (rd_en)
      ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  // sk0 is the head presented downstream; sk1 absorbs the word that
  // was already in flight when tready dropped.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sk0    <= '0;
      sk1    <= '0;
      sk_cnt <= 2'd0;
    end else if (push && pop) begin
      if (sk_cnt == 2'd2) begin
        sk0 <= sk1;
        sk1 <= ram_q;
      end else begin
        sk0 <= ram_q;
      end
    end else if (pop) begin
      sk0    <= sk1;
      sk_cnt <= sk_cnt - 2'd1;
    end else if (push) begin
      if (sk_cnt == 2'd0) sk0 <= ram_q;
      else                sk1 <= ram_q;
      sk_cnt <= sk_cnt + 2'd1;
    end
  end

  assign m00_axis.tvalid = sk_cnt != 2'd0;
  assign {m00_axis.tlast, m00_axis.tkeep, m00_axis.tdata} = sk0;
  assign m00_axis.tuser  = 1'b0;
  assign s00_axis.tready = 1'b1;

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Testbench for rx_frame_fifo: a DEPTH=512 instance for frame/back-pressure
// traffic and a DEPTH=16 instance for overflow and exact-fill cases.
`timescale 1ns/1ps
module tb_rx_frame_fifo;
  localparam int DW = 32;
  localparam int WW = DW + DW / 8 + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_frame_fifo_if #(.DATA_WIDTH(DW)) sa ();
  rx_frame_fifo_if #(.DATA_WIDTH(DW)) ma ();
  rx_frame_fifo_if #(.DATA_WIDTH(DW)) sb ();
  rx_frame_fifo_if #(.DATA_WIDTH(DW)) mb ();

  logic       err_a, ovf_a, err_b, ovf_b;
  logic [9:0] lvl_a;
  logic [4:0] lvl_b;
  logic rdy_a = 1'b1;
  logic rnd_a = 1'b0;
  logic fix_a = 1'b1;
  logic fix_b = 1'b0;

  assign ma.tready = rdy_a;
  assign mb.tready = fix_b;

  always @(posedge clk) begin
    #1;
    rdy_a = rnd_a ? 1'($urandom_range(0, 1)) : fix_a;
  end

  rx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(512)) dut_a (
    .i_clk(clk), .i_reset_n(rst_n),
    .s00_axis(sa), .m00_axis(ma),
    .o_drop_err(err_a), .o_drop_ovf(ovf_a), .o_level(lvl_a)
  );

  rx_frame_fifo #(.DATA_WIDTH(DW), .DEPTH(16)) dut_b (
    .i_clk(clk), .i_reset_n(rst_n),
    .s00_axis(sb), .m00_axis(mb),
    .o_drop_err(err_b), .o_drop_ovf(ovf_b), .o_level(lvl_b)
  );

  int n_chk = 0;
  int n_fail = 0;

  bit sync_a = 1'b1;
  bit sync_b = 1'b1;
  bit force_ovf = 1'b0;
  logic [WW-1:0] cur_a[$], cur_b[$], exp_a[$], exp_b[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: frames are collected whole; a clean tlast moves the
  // frame to the expected-output queue, anything else discards it.
  task automatic beat(input bit sel, input bit v, input logic [31:0] d,
                      input logic [3:0] k, input bit l, input bit u);
    bit e_err, e_ovf;
    logic [WW-1:0] w;
    e_err = 1'b0;
    e_ovf = 1'b0;
    w = {l, k, d};
    if (!sel) begin
      sa.tvalid = v; sa.tdata = d; sa.tkeep = k;
      sa.tlast = l; sa.tuser = u; sb.tvalid = 1'b0;
    end else begin
      sb.tvalid = v; sb.tdata = d; sb.tkeep = k;
      sb.tlast = l; sb.tuser = u; sa.tvalid = 1'b0;
    end
    if (v) begin
      if (sel ? sync_b : sync_a) begin
        if (l && sel) sync_b = 1'b0;
        if (l && !sel) sync_a = 1'b0;
      end else begin
        if (sel) cur_b.push_back(w);
        else cur_a.push_back(w);
        if (l) begin
          if (force_ovf) e_ovf = 1'b1;
          else if (u) e_err = 1'b1;
          else if (sel) begin
            foreach (cur_b[i]) exp_b.push_back(cur_b[i]);
          end else begin
            foreach (cur_a[i]) exp_a.push_back(cur_a[i]);
          end
          if (sel) cur_b.delete();
          else cur_a.delete();
          force_ovf = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    if (sel) begin
      chk("b_drop_err", err_b, e_err);
      chk("b_drop_ovf", ovf_b, e_ovf);
    end else begin
      chk("a_drop_err", err_a, e_err);
      chk("a_drop_ovf", ovf_a, e_ovf);
    end
  endtask

  task automatic idle(input bit sel, input int n);
    repeat (n) beat(sel, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic frame(input bit sel, input int len, input logic [3:0] lk,
                       input bit u, input bit gaps);
    for (int i = 0; i < len; i++) begin
      bit l;
      l = (i == len - 1);
      if (gaps && $urandom_range(0, 2) == 0)
        idle(sel, $urandom_range(1, 3));
      beat(sel, 1'b1, $urandom, l ? lk : 4'hF, l,
           l ? u : 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic wait_drain(input bit sel);
    for (int i = 0; i < 3000; i++) begin
      if (sel ? (exp_b.size() == 0 && !mb.tvalid)
              : (exp_a.size() == 0 && !ma.tvalid)) break;
      idle(sel, 1);
    end
    if (sel) chk("b_drained", 64'(exp_b.size()), 64'd0);
    else chk("a_drained", 64'(exp_a.size()), 64'd0);
  endtask

  task automatic clear_model();
    exp_a.delete(); exp_b.delete();
    cur_a.delete(); cur_b.delete();
    sync_a = 1'b1; sync_b = 1'b1;
    force_ovf = 1'b0;
  endtask

  task automatic do_reset();
    sa.tvalid = 1'b0;
    sb.tvalid = 1'b0;
    rst_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic st_a = 1'b0;
  logic st_b = 1'b0;
  logic [WW-1:0] hold_a, hold_b;

  always @(negedge clk) begin
    if (!rst_n) st_a <= 1'b0;
    else begin
      if (st_a) begin
        chk("a_stall_valid", ma.tvalid, 1'b1);
        chk("a_stall_word", {ma.tlast, ma.tkeep, ma.tdata}, hold_a);
      end
      if (ma.tvalid && ma.tready) begin
        if (exp_a.size() == 0)
          chk("a_beat_unexpected", 64'(exp_a.size()), 64'd1);
        else
          chk("a_beat", {ma.tlast, ma.tkeep, ma.tdata}, exp_a.pop_front());
      end
      st_a <= ma.tvalid && !ma.tready;
      hold_a <= {ma.tlast, ma.tkeep, ma.tdata};
    end
  end

  always @(negedge clk) begin
    if (!rst_n) st_b <= 1'b0;
    else begin
      if (st_b) begin
        chk("b_stall_valid", mb.tvalid, 1'b1);
        chk("b_stall_word", {mb.tlast, mb.tkeep, mb.tdata}, hold_b);
      end
      if (mb.tvalid && mb.tready) begin
        if (exp_b.size() == 0)
          chk("b_beat_unexpected", 64'(exp_b.size()), 64'd1);
        else
          chk("b_beat", {mb.tlast, mb.tkeep, mb.tdata}, exp_b.pop_front());
      end
      st_b <= mb.tvalid && !mb.tready;
      hold_b <= {mb.tlast, mb.tkeep, mb.tdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sa.tvalid = 1'b0; sa.tdata = '0; sa.tkeep = '0;
    sa.tlast = 1'b0; sa.tuser = 1'b0;
    sb.tvalid = 1'b0; sb.tdata = '0; sb.tkeep = '0;
    sb.tlast = 1'b0; sb.tuser = 1'b0;

    #12;
    chk("rst_a_valid", ma.tvalid, 1'b0);
    chk("rst_a_word", {ma.tlast, ma.tkeep, ma.tdata}, 64'd0);
    chk("rst_a_err", err_a, 1'b0);
    chk("rst_a_ovf", ovf_a, 1'b0);
    chk("rst_a_level", lvl_a, 64'd0);
    chk("rst_b_level", lvl_b, 64'd0);
    do_reset();

    // single good frame with latency check
    beat(1'b0, 1'b1, $urandom, 4'hF, 1'b1, 1'b0);
    frame(1'b0, 16, 4'hF, 1'b0, 1'b0);
    chk("lat_edge0", ma.tvalid, 1'b0);
    idle(1'b0, 1);
    chk("lat_edge1", ma.tvalid, 1'b0);
    idle(1'b0, 1);
    chk("lat_edge2", ma.tvalid, 1'b1);
    wait_drain(1'b0);

    // error drop, then a good frame
    frame(1'b0, 16, 4'hF, 1'b1, 1'b0);
    chk("err_level", lvl_a, 64'd0);
    frame(1'b0, 8, 4'hF, 1'b0, 1'b0);
    wait_drain(1'b0);

    // overflow: 10 committed, next frame runs out of room
    do_reset();
    fix_b = 1'b0;
    beat(1'b1, 1'b1, $urandom, 4'hF, 1'b1, 1'b0);
    frame(1'b1, 10, 4'hF, 1'b0, 1'b0);
    chk("ovf_level_commit", lvl_b, 64'd10);
    force_ovf = 1'b1;
    frame(1'b1, 9, 4'hF, 1'b0, 1'b0);
    chk("ovf_level_after", lvl_b, 64'd8);
    fix_b = 1'b1;
    wait_drain(1'b1);

    // exact fill; a 1-beat frame right behind it must overflow
    do_reset();
    fix_b = 1'b0;
    beat(1'b1, 1'b1, $urandom, 4'hF, 1'b1, 1'b0);
    frame(1'b1, 16, 4'hF, 1'b0, 1'b0);
    chk("fill_level", lvl_b, 64'd16);
    force_ovf = 1'b1;
    frame(1'b1, 1, 4'hF, 1'b1, 1'b0);
    fix_b = 1'b1;
    wait_drain(1'b1);

    // back-pressure with input gaps
    beat(1'b0, 1'b1, $urandom, 4'hF, 1'b1, 1'b0);
    rnd_a = 1'b1;
    frame(1'b0, 5, 4'h3, 1'b0, 1'b1);
    frame(1'b0, 7, 4'h3, 1'b0, 1'b1);
    frame(1'b0, 9, 4'h3, 1'b0, 1'b1);
    wait_drain(1'b0);

    // random frames, random errors
    for (int f = 0; f < 24; f++)
      frame(1'b0, $urandom_range(1, 16), 4'($urandom_range(1, 15)),
            $urandom_range(0, 4) == 0, 1'b1);
    wait_drain(1'b0);
    rnd_a = 1'b0;
    fix_a = 1'b1;
    idle(1'b0, 2);

    // reset during beat 5 of 16
    for (int i = 0; i < 4; i++)
      beat(1'b0, 1'b1, $urandom, 4'hF, 1'b0, 1'b0);
    sa.tvalid = 1'b1; sa.tdata = $urandom; sa.tkeep = 4'hF;
    sa.tlast = 1'b0; sa.tuser = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", ma.tvalid, 1'b0);
    chk("midrst_word", {ma.tlast, ma.tkeep, ma.tdata}, 64'd0);
    chk("midrst_level", lvl_a, 64'd0);
    chk("midrst_err", err_a, 1'b0);
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 5; i < 16; i++)
      beat(1'b0, 1'b1, $urandom, 4'hF, i == 15, i == 15);
    chk("midrst_level_sync", lvl_a, 64'd0);
    frame(1'b0, 4, 4'hF, 1'b0, 1'b0);
    wait_drain(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
